// File: rtl/button_event_decoder_pkg.sv
// Shared types and helpers for the button event decoder.
package btn_evt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    LONG_HELD
  } btn_state_t;

  function automatic int unsigned ms_to_cycles(input int unsigned freq, input int unsigned ms);
    return freq / 1000 * ms;
  endfunction

endpackage

// File: rtl/button_event_decoder_if.sv
// Debounced-button level in, single-cycle button events out.
interface button_event_decoder_if;
  import btn_evt_pkg::*;

  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic release_was_long;
  logic long_press_pulse;
  logic repeat_pulse;
  logic held;

  // Producer/consumer of events: drives the level, observes the events.
  modport master (
    output btn_level,
    input  press_pulse,
    input  release_pulse,
    input  release_was_long,
    input  long_press_pulse,
    input  repeat_pulse,
    input  held
  );

  modport slave (
    input  btn_level,
    output press_pulse,
    output release_pulse,
    output release_was_long,
    output long_press_pulse,
    output repeat_pulse,
    output held
  );

endinterface

// File: rtl/button_event_decoder.sv
// Turns a clean button level into press, release, long-press and auto-repeat pulses.
// One FSM with a single shared hold timer; every output is registered.
module button_event_decoder
  import btn_evt_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned LONG_MS   = 1000,
  parameter int unsigned REPEAT_MS = 200,
  parameter bit          REPEAT_EN = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  button_event_decoder_if.slave   bus
);

  localparam int unsigned LongCycles   = ms_to_cycles(CLK_FREQ, LONG_MS);
  localparam int unsigned RepeatCycles = ms_to_cycles(CLK_FREQ, REPEAT_MS);
  localparam int unsigned MaxCycles    = (LongCycles > RepeatCycles) ? LongCycles : RepeatCycles;
  localparam int unsigned TimerW       = $clog2(MaxCycles + 1);

  localparam logic [TimerW-1:0] LongLast   = TimerW'(LongCycles - 1);
  localparam logic [TimerW-1:0] RepeatLast = TimerW'(RepeatCycles - 1);

  if (LongCycles < 2 || RepeatCycles < 1) begin : g_param_check
    $error("button_event_decoder: LONG_CYCLES must be >= 2 and REPEAT_CYCLES >= 1");
  end

  btn_state_t        r_state;
  logic [TimerW-1:0] r_timer;
  logic              r_press;
  logic              r_release;
  logic              r_was_long;
  logic              r_long;
  logic              r_repeat;
  logic              r_held;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_timer    <= '0;
      r_press    <= 1'b0;
      r_release  <= 1'b0;
      r_was_long <= 1'b0;
      r_long     <= 1'b0;
      r_repeat   <= 1'b0;
      r_held     <= 1'b0;
    end else begin
      r_press    <= 1'b0;
      r_release  <= 1'b0;
      r_was_long <= 1'b0;
      r_long     <= 1'b0;
      r_repeat   <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.btn_level) begin
            r_press <= 1'b1;
            r_state <= PRESSED;
            r_timer <= '0;
            r_held  <= 1'b1;
          end else begin
            r_held  <= 1'b0;
          end
        end
        // Release is checked before timer expiry so the release edge never carries a long pulse.
        PRESSED: begin
          if (!bus.btn_level) begin
            r_release <= 1'b1;
            r_state   <= IDLE;
            r_timer   <= '0;
            r_held    <= 1'b0;
          end else if (r_timer == LongLast) begin
            r_long  <= 1'b1;
            r_state <= LONG_HELD;
            r_timer <= '0;
            r_held  <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
            r_held  <= 1'b1;
          end
        end
        LONG_HELD: begin
          if (!bus.btn_level) begin
            r_release  <= 1'b1;
            r_was_long <= 1'b1;
            r_state    <= IDLE;
            r_timer    <= '0;
            r_held     <= 1'b0;
          end else if (r_timer == RepeatLast) begin
            r_repeat <= REPEAT_EN;
            r_timer  <= '0;
            r_held   <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
            r_held  <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_timer <= '0;
          r_held  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.press_pulse      = r_press;
  assign bus.release_pulse    = r_release;
  assign bus.release_was_long = r_was_long;
  assign bus.long_press_pulse = r_long;
  assign bus.repeat_pulse     = r_repeat;
  assign bus.held             = r_held;

endmodule

// File: tb/tb_button_event_decoder.sv
// Random and directed stimulus on two decoders (repeat enabled/disabled) against a
// hold-length reference model.
module tb_button_event_decoder;

  localparam int unsigned L = 10;
  localparam int unsigned R = 3;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  button_event_decoder_if bus_a ();
  button_event_decoder_if bus_b ();

  button_event_decoder #(
    .CLK_FREQ (1000),
    .LONG_MS  (10),
    .REPEAT_MS(3),
    .REPEAT_EN(1'b1)
  ) u_dut_a (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_a)
  );

  button_event_decoder #(
    .CLK_FREQ (1000),
    .LONG_MS  (10),
    .REPEAT_MS(3),
    .REPEAT_EN(1'b0)
  ) u_dut_b (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_b)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Model: per DUT, whether a press is in progress and how many edges since the press edge.
  bit          m_active [2];
  int unsigned m_edges  [2];
  logic [5:0]  m_exp    [2];  // {held, repeat, long, was_long, release, press}
  int unsigned n_long_b = 0;
  int unsigned n_rep_b  = 0;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input int d, input logic btn, input logic rst, input bit rep_en);
    logic [5:0] e;
    e = '0;
    if (rst) begin
      m_active[d] = 1'b0;
      m_edges[d]  = 0;
    end else if (!m_active[d]) begin
      if (btn) begin
        m_active[d] = 1'b1;
        m_edges[d]  = 0;
        e[0] = 1'b1;
        e[5] = 1'b1;
      end
    end else begin
      m_edges[d]++;
      if (!btn) begin
        e[1] = 1'b1;
        e[2] = (m_edges[d] > L);
        m_active[d] = 1'b0;
      end else begin
        e[3] = (m_edges[d] == L);
        e[4] = rep_en && (m_edges[d] > L) && ((m_edges[d] - L) % R == 0);
        e[5] = 1'b1;
      end
    end
    m_exp[d] = e;
  endtask

  task automatic step(input logic btn, input logic rst);
    logic [5:0] got_a, got_b;
    reset = rst;
    bus_a.btn_level = btn;
    bus_b.btn_level = btn;
    @(posedge clk);
    model_edge(0, btn, rst, 1'b1);
    model_edge(1, btn, rst, 1'b0);
    #1;
    got_a = {bus_a.held, bus_a.repeat_pulse, bus_a.long_press_pulse,
             bus_a.release_was_long, bus_a.release_pulse, bus_a.press_pulse};
    got_b = {bus_b.held, bus_b.repeat_pulse, bus_b.long_press_pulse,
             bus_b.release_was_long, bus_b.release_pulse, bus_b.press_pulse};
    check_eq("outs_rep_en", got_a, m_exp[0]);
    check_eq("outs_rep_dis", got_b, m_exp[1]);
    check_eq("onehot_a", ($countones({got_a[4:3], got_a[1:0]}) <= 1), 1);
    check_eq("onehot_b", ($countones({got_b[4:3], got_b[1:0]}) <= 1), 1);
    n_long_b += got_b[3];
    n_rep_b  += got_b[4];
  endtask

  task automatic hold(input int unsigned n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0);
  endtask

  task automatic idle(input int unsigned n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    bus_a.btn_level = 1'b1;
    bus_b.btn_level = 1'b1;

    // Reset with button held, then release reset: fresh press.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    hold(3);
    idle(3);

    // Short press.
    hold(6);
    idle(2);

    // Long hold with repeats; also the repeat-disabled counting window.
    n_long_b = 0;
    n_rep_b  = 0;
    hold(31);
    check_eq("long_count_dis", n_long_b, 1);
    check_eq("repeat_count_dis", n_rep_b, 0);
    idle(2);

    // Release on the cycle the timer would expire.
    hold(L);
    idle(2);

    // Glitch.
    hold(1);
    idle(3);

    // Reset in LONG_HELD.
    hold(15);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    idle(2);

    for (int it = 0; it < 80; it++) begin
      int unsigned h;
      h = $urandom_range(1, 30);
      for (int j = 0; j < h; j++) step(1'b1, ($urandom_range(0, 99) == 0));
      idle($urandom_range(1, 4));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
